// File: rtl/deconv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : deconv_layer_sequencer
// Description : Layer controller for the transposed-convolution core. It checks
//               the layer config, walks the loop nest, drains the core and then
//               streams the output-buffer read addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module deconv_layer_sequencer #(
    parameter int PIPE_DEPTH = 8,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        cfg_h,
    input  logic [5:0]        cfg_w,
    input  logic [6:0]        cfg_k,
    input  logic [2:0]        cfg_hk,
    input  logic              stall,
    output logic              core_en,
    output logic              iter_valid,
    output logic [4:0]        m,
    output logic [4:0]        n,
    output logic [1:0]        mk,
    output logic [1:0]        nk,
    output logic [5:0]        ck,
    output logic              last_iter,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CHECK = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_READ  = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    localparam int                    c_DRAIN_W    = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [c_DRAIN_W-1:0]  c_DRAIN_LAST = c_DRAIN_W'(PIPE_DEPTH - 1);
    localparam logic [31:0]           c_MAX_AREA   = 32'd1 << ADDR_W;

    logic [2:0]           r_state;
    logic [5:0]           r_h;
    logic [5:0]           r_w;
    logic [6:0]           r_k;
    logic [2:0]           r_hk;
    logic [4:0]           r_m;
    logic [4:0]           r_n;
    logic [1:0]           r_mk;
    logic [1:0]           r_nk;
    logic [5:0]           r_ck;
    logic [c_DRAIN_W-1:0] r_drain;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [ADDR_W-1:0]    r_last_addr;
    logic                 r_done;
    logic                 r_err;

    logic [6:0]  w_oh;
    logic [6:0]  w_ow;
    logic [13:0] w_area;
    logic        w_cfg_bad;
    logic        w_ck_end;
    logic        w_nk_end;
    logic        w_mk_end;
    logic        w_n_end;
    logic        w_m_end;
    logic        w_last_iter;
    logic        w_rd_end;

    // Output extent is computed at full 14-bit width so oversize layers cannot alias.
    assign w_oh   = {1'b0, r_h} + {4'd0, r_hk} - 7'd1;
    assign w_ow   = {1'b0, r_w} + {4'd0, r_hk} - 7'd1;
    assign w_area = {7'd0, w_oh} * {7'd0, w_ow};

    assign w_cfg_bad = (r_h == 6'd0) || (r_h > 6'd32) ||
                       (r_w == 6'd0) || (r_w > 6'd32) ||
                       (r_hk == 3'd0) || (r_hk > 3'd3) ||
                       (r_k == 7'd0) || (r_k > 7'd64) ||
                       ({18'd0, w_area} > c_MAX_AREA);

    assign w_ck_end    = ({1'b0, r_ck} == r_k - 7'd1);
    assign w_nk_end    = ({1'b0, r_nk} == r_hk - 3'd1);
    assign w_mk_end    = ({1'b0, r_mk} == r_hk - 3'd1);
    assign w_n_end     = ({1'b0, r_n} == r_w - 6'd1);
    assign w_m_end     = ({1'b0, r_m} == r_h - 6'd1);
    assign w_last_iter = w_ck_end && w_nk_end && w_mk_end && w_n_end && w_m_end;
    assign w_rd_end    = (r_rd_addr == r_last_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_h         <= 6'd0;
            r_w         <= 6'd0;
            r_k         <= 7'd0;
            r_hk        <= 3'd0;
            r_m         <= 5'd0;
            r_n         <= 5'd0;
            r_mk        <= 2'd0;
            r_nk        <= 2'd0;
            r_ck        <= 6'd0;
            r_drain     <= '0;
            r_rd_addr   <= '0;
            r_last_addr <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_h     <= cfg_h;
                        r_w     <= cfg_w;
                        r_k     <= cfg_k;
                        r_hk    <= cfg_hk;
                        r_err   <= 1'b0;
                        r_state <= c_CHECK;
                    end
                end
                c_CHECK: begin
                    if (w_cfg_bad) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_m         <= 5'd0;
                        r_n         <= 5'd0;
                        r_mk        <= 2'd0;
                        r_nk        <= 2'd0;
                        r_ck        <= 6'd0;
                        r_last_addr <= ADDR_W'(w_area - 14'd1);
                        r_state     <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (!stall) begin
                        if (w_last_iter) begin
                            r_drain <= '0;
                            r_state <= c_DRAIN;
                        end else if (!w_ck_end) begin
                            r_ck <= r_ck + 6'd1;
                        end else begin
                            // Ripple carry through nk, mk, n, m (ck innermost).
                            r_ck <= 6'd0;
                            if (!w_nk_end) begin
                                r_nk <= r_nk + 2'd1;
                            end else begin
                                r_nk <= 2'd0;
                                if (!w_mk_end) begin
                                    r_mk <= r_mk + 2'd1;
                                end else begin
                                    r_mk <= 2'd0;
                                    if (!w_n_end) begin
                                        r_n <= r_n + 5'd1;
                                    end else begin
                                        r_n <= 5'd0;
                                        r_m <= r_m + 5'd1;
                                    end
                                end
                            end
                        end
                    end
                end
                c_DRAIN: begin
                    if (r_drain == c_DRAIN_LAST) begin
                        r_rd_addr <= '0;
                        r_state   <= c_READ;
                    end else begin
                        r_drain <= r_drain + c_DRAIN_W'(1);
                    end
                end
                c_READ: begin
                    if (!stall) begin
                        if (w_rd_end) begin
                            r_done  <= 1'b1;
                            r_state <= c_DONE;
                        end else begin
                            r_rd_addr <= r_rd_addr + ADDR_W'(1);
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != c_IDLE);
    assign iter_valid = (r_state == c_RUN);
    assign core_en    = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign rd_valid   = (r_state == c_READ);
    assign last_iter  = (r_state == c_RUN) && w_last_iter;
    assign rd_last    = (r_state == c_READ) && w_rd_end;
    assign m          = r_m;
    assign n          = r_n;
    assign mk         = r_mk;
    assign nk         = r_nk;
    assign ck         = r_ck;
    assign rd_addr    = r_rd_addr;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_deconv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_deconv_layer_sequencer
// Description : Scoreboard bench for deconv_layer_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deconv_layer_sequencer;

    localparam int ADDR_W     = 10;
    localparam int PIPE_DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [5:0]        cfg_h = '0;
    logic [5:0]        cfg_w = '0;
    logic [6:0]        cfg_k = '0;
    logic [2:0]        cfg_hk = '0;
    logic              stall = 1'b0;
    logic              core_en, iter_valid, last_iter, rd_valid, rd_last, busy, done, err;
    logic [4:0]        m, n;
    logic [1:0]        mk, nk;
    logic [5:0]        ck;
    logic [ADDR_W-1:0] rd_addr;

    deconv_layer_sequencer #(.PIPE_DEPTH(PIPE_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_k(cfg_k), .cfg_hk(cfg_hk), .stall(stall),
        .core_en(core_en), .iter_valid(iter_valid),
        .m(m), .n(n), .mk(mk), .nk(nk), .ck(ck), .last_iter(last_iter),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_last(rd_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [20:0]     exp_iter[$];
    logic [ADDR_W:0] exp_rd[$];

    // Layer results gathered by run_layer
    int res_iter, res_drain, res_rd, res_done_cyc, res_last_rd_cyc, res_last_addr;
    bit res_err, res_busy, res_timeout;

    // Scoreboard: compare against queue head every valid cycle, pop only when the DUT advances.
    always @(negedge clk) begin
        if (iter_valid) begin
            checks++;
            if (exp_iter.size() == 0) begin
                errors++;
                $display("FAIL iter_unexpected: got %h with empty queue", {m, n, mk, nk, ck, last_iter});
            end else begin
                if ({m, n, mk, nk, ck, last_iter} !== exp_iter[0]) begin
                    errors++;
                    $display("FAIL iter_seq: got %h expected %h", {m, n, mk, nk, ck, last_iter}, exp_iter[0]);
                end
                if (!stall) void'(exp_iter.pop_front());
            end
        end
        if (rd_valid) begin
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %h with empty queue", {rd_addr, rd_last});
            end else begin
                if ({rd_addr, rd_last} !== exp_rd[0]) begin
                    errors++;
                    $display("FAIL rd_seq: got %h expected %h", {rd_addr, rd_last}, exp_rd[0]);
                end
                if (!stall) void'(exp_rd.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_layer(input int h, input int w, input int k, input int hk);
        int area;
        logic [20:0] v;
        for (int a = 0; a < h; a++)
            for (int b = 0; b < w; b++)
                for (int c = 0; c < hk; c++)
                    for (int d = 0; d < hk; d++)
                        for (int e = 0; e < k; e++) begin
                            v = {5'(a), 5'(b), 2'(c), 2'(d), 6'(e),
                                 (a == h-1 && b == w-1 && c == hk-1 && d == hk-1 && e == k-1)};
                            exp_iter.push_back(v);
                        end
        area = (h + hk - 1) * (w + hk - 1);
        for (int a = 0; a < area; a++)
            exp_rd.push_back({ADDR_W'(a), (a == area - 1)});
    endtask

    // stall_mode: 0 none, 1 three cycles at first ck==1 in RUN, 2 throughout DRAIN
    task automatic run_layer(input int h, input int w, input int k, input int hk,
                             input int stall_mode, input bit hold);
        int stall_cnt;
        bit stalled_once;
        cfg_h = 6'(h); cfg_w = 6'(w); cfg_k = 7'(k); cfg_hk = 3'(hk);
        start = 1'b1;
        res_iter = 0; res_drain = 0; res_rd = 0; res_done_cyc = -1;
        res_last_rd_cyc = -1; res_last_addr = -1; res_err = 0; res_busy = 0; res_timeout = 1;
        stall_cnt = 0; stalled_once = 0;
        for (int cyc = 1; cyc <= 20000; cyc++) begin
            tick;
            if (!hold) start = 1'b0;
            if (iter_valid) res_iter++;
            if (core_en && !iter_valid) res_drain++;
            if (rd_valid) res_rd++;
            if (rd_last) begin
                res_last_rd_cyc = cyc;
                res_last_addr   = int'(rd_addr);
            end
            if (stall_mode == 1) begin
                if (stall_cnt > 0) begin
                    stall_cnt--;
                    if (stall_cnt == 0) stall = 1'b0;
                end else if (!stalled_once && iter_valid && ck == 6'd1) begin
                    stall = 1'b1; stall_cnt = 3; stalled_once = 1;
                end
            end else if (stall_mode == 2) begin
                stall = core_en && !iter_valid;
            end
            if (done) begin
                res_done_cyc = cyc; res_err = err; res_busy = busy; res_timeout = 0;
                break;
            end
        end
        stall = 1'b0;
        checks++;
        if (res_timeout) begin
            errors++;
            $display("FAIL layer_timeout: no done within 20000 cycles (h=%0d w=%0d k=%0d hk=%0d)", h, w, k, hk);
        end
    endtask

    task automatic test_queues_empty(input string tag);
        checks++;
        if (exp_iter.size() != 0 || exp_rd.size() != 0) begin
            errors++;
            $display("FAIL %s_queue: %0d iter and %0d rd entries left, required 0", tag, exp_iter.size(), exp_rd.size());
        end
        exp_iter.delete();
        exp_rd.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        checks++;
        if ({core_en, iter_valid, m, n, mk, nk, ck, last_iter, rd_valid, rd_addr, rd_last, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {core_en, iter_valid, m, n, mk, nk, ck, last_iter, rd_valid, rd_addr, rd_last, busy, done, err});
        end
        rst_n = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_basic;
        push_layer(2, 2, 2, 2);
        run_layer(2, 2, 2, 2, 0, 0);
        checks++; if (res_iter != 32) begin errors++; $display("FAIL basic_iters: got %0d required 32", res_iter); end
        checks++; if (res_drain != 8) begin errors++; $display("FAIL basic_drain: got %0d required 8", res_drain); end
        checks++; if (res_rd != 9) begin errors++; $display("FAIL basic_rd_count: got %0d required 9", res_rd); end
        checks++; if (res_last_addr != 8) begin errors++; $display("FAIL basic_rd_last_addr: got %0d required 8", res_last_addr); end
        checks++; if (res_done_cyc != res_last_rd_cyc + 1) begin errors++; $display("FAIL basic_done_after_last: got %0d required %0d", res_done_cyc, res_last_rd_cyc + 1); end
        checks++; if (res_done_cyc != 51) begin errors++; $display("FAIL basic_done_cycle: got %0d required 51", res_done_cyc); end
        checks++; if (res_err !== 1'b0 || res_busy !== 1'b1) begin errors++; $display("FAIL basic_done_flags: got err=%b busy=%b required err=0 busy=1", res_err, res_busy); end
        test_queues_empty("basic");
        tick;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_back_idle: got busy=%b done=%b required 0 0", busy, done); end
    endtask

    task automatic test_reject(input int h, input int w, input int k, input int hk, input string tag);
        run_layer(h, w, k, hk, 0, 0);
        checks++; if (res_done_cyc != 2) begin errors++; $display("FAIL %s_done_cycle: got %0d required 2", tag, res_done_cyc); end
        checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL %s_err: got %b required 1", tag, res_err); end
        checks++; if (res_iter != 0 || res_rd != 0) begin errors++; $display("FAIL %s_no_activity: got iter=%0d rd=%0d required 0 0", tag, res_iter, res_rd); end
        tick;
        checks++; if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_err_held: got err=%b done=%b busy=%b required 1 0 0", tag, err, done, busy); end
    endtask

    task automatic test_area_limit;
        test_reject(32, 32, 1, 2, "area_1089");
        push_layer(31, 31, 1, 2);
        run_layer(31, 31, 1, 2, 0, 0);
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL area_1024_err: got %b required 0", res_err); end
        checks++; if (res_rd != 1024 || res_last_addr != 1023) begin errors++; $display("FAIL area_1024_rd: got count=%0d last=%0d required 1024 1023", res_rd, res_last_addr); end
        checks++; if (res_iter != 3844) begin errors++; $display("FAIL area_1024_iters: got %0d required 3844", res_iter); end
        test_queues_empty("area_1024");
        tick;
    endtask

    task automatic test_stall_run;
        push_layer(2, 2, 2, 2);
        run_layer(2, 2, 2, 2, 1, 0);
        checks++; if (res_iter != 35) begin errors++; $display("FAIL stall_run_iters: got %0d required 35", res_iter); end
        checks++; if (res_drain != 8) begin errors++; $display("FAIL stall_run_drain: got %0d required 8", res_drain); end
        test_queues_empty("stall_run");
        tick;
    endtask

    task automatic test_stall_drain;
        push_layer(2, 2, 2, 2);
        run_layer(2, 2, 2, 2, 2, 0);
        checks++; if (res_drain != 8) begin errors++; $display("FAIL stall_drain_len: got %0d required 8", res_drain); end
        checks++; if (res_done_cyc != 51) begin errors++; $display("FAIL stall_drain_done: got %0d required 51", res_done_cyc); end
        test_queues_empty("stall_drain");
        tick;
    endtask

    task automatic test_reset_mid_run;
        push_layer(2, 2, 2, 2);
        cfg_h = 6'd2; cfg_w = 6'd2; cfg_k = 7'd2; cfg_hk = 3'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (6) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        exp_iter.delete();
        exp_rd.delete();
        checks++;
        if ({core_en, iter_valid, m, n, mk, nk, ck, last_iter, rd_valid, rd_addr, rd_last, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h required 0",
                     {core_en, iter_valid, m, n, mk, nk, ck, last_iter, rd_valid, rd_addr, rd_last, busy, done, err});
        end
        push_layer(2, 2, 2, 2);
        run_layer(2, 2, 2, 2, 0, 0);
        checks++; if (res_iter != 32 || res_done_cyc != 51 || res_err !== 1'b0) begin errors++; $display("FAIL midreset_restart: got iter=%0d done_cyc=%0d err=%b required 32 51 0", res_iter, res_done_cyc, res_err); end
        test_queues_empty("midreset");
        tick;
    endtask

    task automatic test_back_to_back_start_held;
        int it2;
        bit seen;
        push_layer(1, 1, 1, 1);
        push_layer(1, 1, 1, 1);
        run_layer(1, 1, 1, 1, 0, 1);
        checks++; if (res_iter != 1 || res_rd != 1) begin errors++; $display("FAIL held_first: got iter=%0d rd=%0d required 1 1", res_iter, res_rd); end
        checks++; if (res_done_cyc != 12) begin errors++; $display("FAIL held_done_cycle: got %0d required 12", res_done_cyc); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle_gap: got busy=%b required 0", busy); end
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_restart: got busy=%b required 1", busy); end
        start = 1'b0;
        it2 = 0; seen = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick;
            if (iter_valid) it2++;
            if (done) begin seen = 1; break; end
        end
        checks++; if (!seen || it2 != 1) begin errors++; $display("FAIL held_second: got done=%b iter=%0d required 1 1", seen, it2); end
        test_queues_empty("held");
        tick;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject(2, 2, 2, 0, "reject_hk0");
        test_reject(40, 2, 2, 2, "reject_h40");
        test_area_limit();
        test_stall_run();
        test_stall_drain();
        test_reset_mid_run();
        test_back_to_back_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded 1000000 time units");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
